// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: initial AddRoundKey on accept, then one round per clock.
// Round keys are read combinationally from an external schedule store indexed by rk_idx.
module aes_round_engine #(
  parameter int KEY_BITS = 128,
  parameter int RIDX_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      pt,
  output logic [RIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      ct,
  output logic              busy
);
  localparam int NR = (KEY_BITS == 256) ? 14 : 10;

  generate
    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_round_engine: KEY_BITS must be 128 or 256");
    end
    if ((1 << RIDX_W) <= NR) begin : g_bad_ridx_w
      $error("aes_round_engine: RIDX_W too narrow for NR");
    end
  endgenerate

  typedef logic [15:0][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b occupies bits [2047-8b -: 8], and 2047-8b == {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    blk_t v;
    blk_t r;
    v = s;
    for (int unsigned i = 0; i < 16; i++) r[i] = sbox(v[i]);
    return r;
  endfunction

  // Byte n of the block is element 15-n; row r of column c rotates left by r.
  function automatic logic [127:0] shift_row(input logic [127:0] s);
    blk_t v;
    v = s;
    return {v[15], v[10], v[5],  v[0],  v[11], v[6], v[1],  v[12],
            v[7],  v[2],  v[13], v[8],  v[3],  v[14], v[9], v[4]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  state_t              state_q, state_d;
  logic [127:0]        blk_q, blk_d;
  logic [RIDX_W-1:0]   round_q, round_d;
  logic [127:0]        sr_out, mc_out;

  always_comb begin
    sr_out = shift_row(sub_bytes(blk_q));
    mc_out = mix_columns(sr_out);
  end

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = add_round_key(pt, rk);
          round_d = RIDX_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        rk_idx = round_q;
        if (round_q == RIDX_W'(NR)) begin
          blk_d   = add_round_key(sr_out, rk);
          state_d = DONE;
        end else begin
          blk_d   = add_round_key(mc_out, rk);
          round_d = round_q + 1'b1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The final round lands in the state register itself; ct exposes it only while DONE.
    ct = out_valid ? blk_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      round_q <= round_d;
    end
  end
endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine: AES-128 and AES-256 instances against a
// GF(2^8)-derived reference model, FIPS-197 vectors, backpressure, reset and streaming.
module tb_aes_round_engine;
  logic clk = 1'b0;
  logic rst, sel, in_valid, out_ready;
  logic [127:0] pt;
  logic a_in_ready, a_out_valid, a_busy, b_in_ready, b_out_valid, b_busy;
  logic [3:0] a_rk_idx, b_rk_idx;
  logic [127:0] a_rk, b_rk, a_ct, b_ct;
  logic [127:0] rks_a [16];
  logic [127:0] rks_b [16];
  logic [127:0] ks [16];
  logic [7:0] sbox_m [256];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic bad_idx = 1'b0;

  logic o_in_ready, o_out_valid, o_busy;
  logic [3:0] o_rk_idx;
  logic [127:0] o_ct;

  typedef struct {
    int           kbits;
    logic [255:0] key;
    logic [127:0] p;
    logic [127:0] c;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (a_rk_idx > 4'd10 || b_rk_idx > 4'd14) bad_idx <= 1'b1;

  assign a_rk        = rks_a[a_rk_idx];
  assign b_rk        = rks_b[b_rk_idx];
  assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign o_out_valid = sel ? b_out_valid : a_out_valid;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_rk_idx    = sel ? b_rk_idx    : a_rk_idx;
  assign o_ct        = sel ? b_ct        : a_ct;

  aes_round_engine u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(a_in_ready), .pt(pt),
    .rk_idx(a_rk_idx), .rk(a_rk), .out_valid(a_out_valid), .out_ready(out_ready & ~sel),
    .ct(a_ct), .busy(a_busy)
  );

  aes_round_engine #(.KEY_BITS(256)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(b_in_ready), .pt(pt),
    .rk_idx(b_rk_idx), .rk(b_rk), .out_valid(b_out_valid), .out_ready(out_ready & sel),
    .ct(b_ct), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] av, inv, t, s;
    for (int a = 0; a < 256; a++) begin
      av  = 8'(a);
      inv = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(av, 8'(x)) == 8'h01) inv = 8'(x);
      s = inv; t = inv;
      for (int k = 0; k < 4; k++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      sbox_m[a] = s ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [255:0] key, input int kbits);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = kbits / 32; nr = nk + 6; rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < 16; j++) begin
      if (j <= nr) ks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
      else         ks[j] = '0;
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] p, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ ks[0][127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[rw + 4*c] = t[rw + 4*((c + rw) % 4)];
      if (rd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[rd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic prep(input bit s, input logic [255:0] key);
    sel = s;
    expand(key, s ? 256 : 128);
    for (int j = 0; j < 16; j++) begin
      if (s) rks_b[j] = ks[j];
      else   rks_a[j] = ks[j];
    end
    #1;
  endtask

  // Offers one block, follows it through every round and the output handshake.
  task automatic run_block(input logic [127:0] p, input logic [127:0] exp, input bit keep_valid,
                           input int hold, input string nm, output int acc);
    int nr, w;
    nr = sel ? 14 : 10;
    out_ready = (hold == 0);
    pt = p;
    in_valid = 1'b1;
    w = 0;
    while (!o_in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!o_in_ready) begin
      chk({nm, " accept timeout"}, 128'(o_in_ready), 128'd1);
      in_valid = 1'b0;
      acc = 0;
      return;
    end
    chk({nm, " rk_idx"}, 128'(o_rk_idx), 128'd0);
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k <= nr; k++) begin
      chk({nm, " rk_idx"}, 128'(o_rk_idx), 128'(k));
      chk({nm, " out_valid early"}, 128'(o_out_valid), 128'd0);
      chk({nm, " in_ready busy"}, 128'(o_in_ready), 128'd0);
      chk({nm, " busy"}, 128'(o_busy), 128'd1);
      @(negedge clk);
    end
    chk({nm, " out_valid"}, 128'(o_out_valid), 128'd1);
    chk({nm, " ct"}, o_ct, exp);
    for (int i = 0; i < hold; i++) begin
      chk({nm, " hold ct"}, o_ct, exp);
      chk({nm, " hold out_valid"}, 128'(o_out_valid), 128'd1);
      chk({nm, " hold in_ready"}, 128'(o_in_ready), 128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, " idle out_valid"}, 128'(o_out_valid), 128'd0);
    chk({nm, " idle in_ready"}, 128'(o_in_ready), 128'd1);
    chk({nm, " idle busy"}, 128'(o_busy), 128'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [3];
    logic [255:0] key;
    logic [127:0] p, exp_ct;
    int acc0, acc1;
    bit seen;

    vt[0] = '{128, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vt[1] = '{128, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vt[2] = '{256, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};

    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pt = '0;
    for (int j = 0; j < 16; j++) begin
      rks_a[j] = '0;
      rks_b[j] = '0;
    end
    build_sbox();

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("reset in_ready", 128'(o_in_ready), 128'd1);
      chk("reset out_valid", 128'(o_out_valid), 128'd0);
      chk("reset busy", 128'(o_busy), 128'd0);
      chk("reset rk_idx", 128'(o_rk_idx), 128'd0);
      chk("reset ct", o_ct, 128'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 3; v++) begin
      prep(vt[v].kbits == 256, vt[v].key);
      chk("model vector", model_encrypt(vt[v].p, vt[v].kbits == 256 ? 14 : 10), vt[v].c);
      run_block(vt[v].p, vt[v].c, 1'b0, 0, $sformatf("vec%0d", v), acc0);
    end

    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 4; n++) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        p   = {$urandom, $urandom, $urandom, $urandom};
        prep(1'(s), key);
        exp_ct = model_encrypt(p, s ? 14 : 10);
        run_block(p, exp_ct, 1'b0, (n == 3) ? 3 : 0, $sformatf("rand%0d_%0d", s, n), acc0);
      end
    end

    prep(1'b0, vt[0].key);
    run_block(vt[0].p, vt[0].c, 1'b1, 20, "bp1", acc0);
    p = {$urandom, $urandom, $urandom, $urandom};
    exp_ct = model_encrypt(p, 10);
    run_block(p, exp_ct, 1'b0, 0, "bp2", acc1);
    chk("bp accept interval", 128'(acc1 - acc0), 128'd32);

    for (int s = 0; s < 2; s++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      prep(1'(s), key);
      acc0 = 0;
      for (int n = 0; n < 3; n++) begin
        p = {$urandom, $urandom, $urandom, $urandom};
        exp_ct = model_encrypt(p, s ? 14 : 10);
        run_block(p, exp_ct, 1'b1, 0, $sformatf("b2b%0d_%0d", s, n), acc1);
        if (n > 0) chk("b2b accept interval", 128'(acc1 - acc0), 128'(s ? 16 : 12));
        acc0 = acc1;
      end
      in_valid = 1'b0;
      @(negedge clk);
    end

    prep(1'b0, vt[0].key);
    pt = vt[0].p; in_valid = 1'b1; out_ready = 1'b1;
    chk("rst_mid in_ready", 128'(o_in_ready), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid rk_idx", 128'(o_rk_idx), 128'd5);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid in_ready", 128'(o_in_ready), 128'd1);
    chk("rst_mid out_valid", 128'(o_out_valid), 128'd0);
    chk("rst_mid busy", 128'(o_busy), 128'd0);
    chk("rst_mid rk_idx0", 128'(o_rk_idx), 128'd0);
    chk("rst_mid ct", o_ct, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (o_out_valid || o_busy) seen = 1'b1;
    end
    chk("rst_mid no output", 128'(seen), 128'd0);
    run_block(vt[0].p, vt[0].c, 1'b0, 0, "post_rst", acc0);

    chk("rk_idx bound", 128'(bad_idx), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES encryption core: one round per clock, with a valid/ready handshake on the input and output sides.
- Generalises the single-shot combinational first-round datapath into a full multi-round engine, parametrised for AES-128 or AES-256.
- Reuses the team's existing sub_bytes, shift_row, mix_columns and Add_Round_Key blocks.
- Round keys come from an external key-schedule store through an indexed combinational read port.

Parameters:
- KEY_BITS, 128, key size; legal values 128 or 256 only; any other value is an elaboration error.
- NR, derived (10 if KEY_BITS=128, 14 if 256), number of rounds; not overridable.
- RIDX_W, 4, width of the round-key index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a plaintext block is offered.
- in_ready  output  1  engine can accept a block.
- pt  input  128  plaintext; byte 0 = pt[127:120]; column-major state order.
- rk_idx  output  RIDX_W  index of the round key required this cycle.
- rk  input  128  round key rk_idx; combinational from the store, valid in the same cycle.
- out_valid  output  1  ciphertext is available.
- out_ready  input  1  consumer accepts the ciphertext.
- ct  output  128  ciphertext.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, state register=0, round counter=0, in_ready=1, out_valid=0, ct=0, busy=0, rk_idx=0.
- FSM, IDLE:
  - in_ready=1; rk_idx=0.
  - On in_valid&&in_ready: state_reg <= pt ^ rk (initial AddRoundKey); round <= 1; go to RUN.
  - pt is sampled only in the accept cycle.
- FSM, RUN:
  - in_ready=0; rk_idx=round.
  - If round<NR: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ rk; round <= round+1.
  - If round==NR: ct <= ShiftRows(SubBytes(state_reg)) ^ rk (MixColumns skipped); go to DONE.
- FSM, DONE:
  - out_valid=1; ct is held stable until out_ready.
  - On out_ready: out_valid <= 0; go to IDLE.
  - No new block is accepted in DONE, even in the same cycle as out_ready.
- Latency:
  - Accept in cycle T. out_valid rises at the edge ending cycle T+NR, so it is visible in cycle T+NR+1 (T+11 for AES-128, T+15 for AES-256).
  - Minimum issue interval is NR+2 cycles.
- Datapath: the only registered state is a single 128-bit state register. The round logic between registers is the combinational SubBytes→ShiftRows→MixColumns→XOR path; the final round bypasses MixColumns.
- Round-key order: the sequence rk_idx=0..NR is driven exactly once per block, in increasing order. rk_idx is never greater than NR.
- Backpressure: out_ready held low keeps DONE indefinitely, with ct and out_valid constant.
- Input handling: in_valid is ignored outside IDLE. pt changing mid-operation has no effect.
- Reset mid-operation: rst asserted in any state forces the reset values immediately. The partial result is discarded and no out_valid pulse occurs.
- Simultaneous events:
  - out_ready high in a cycle with out_valid=0 has no effect.
  - in_valid and out_ready both high in DONE: only the output handshake completes.
- Encryption only; no decryption mode.

Test Plan:
- AES-128 FIPS-197 C.1:
  - Stimulus: round keys expanded by the bench from key 000102030405060708090a0b0c0d0e0f; pt=00112233445566778899aabbccddeeff.
  - Required: ct=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid first high exactly 11 cycles after the accept cycle; rk_idx sequence 0..10 checked.
- AES-256 FIPS-197 C.3 (KEY_BITS=256):
  - Stimulus: key 000102…1e1f; same pt.
  - Required: ct=8ea2b7ca516745bfeafc49904b496089; latency 15 cycles; rk_idx reaches 14 and never 15.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid, with in_valid=1 throughout.
  - Required: ct stable, in_ready=0, no second accept; out_ready=1 → IDLE next cycle, then the second block is accepted.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between clock edges) during RUN round 5.
  - Required: outputs return to reset values immediately; no out_valid; the next block after reset gives the correct C.1 ciphertext.
- Back-to-back blocks:
  - Stimulus: three blocks with in_valid and out_ready held high.
  - Required: accepts spaced NR+2 cycles apart; each ct matches the bench model; in_valid is ignored while busy.
